// File: rtl/draw_pkg.sv
// Shared screen geometry, colour codes and the circle engine state type
// for the pixel drawing blocks that feed the VGA adapter.
package draw_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;
  localparam int X_W           = 8;
  localparam int Y_W           = 7;
  localparam int R_W           = 7;
  // Decision variable needs two bits of headroom over the signed radius.
  localparam int C_W           = R_W + 3;

  localparam logic [2:0] BLACK  = 3'b000;
  localparam logic [2:0] BLUE   = 3'b001;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] WHITE  = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLOT   = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/circle_octant_point.sv
// Maps one octant index plus the current (ox, oy) offset onto a screen
// point and flags whether that point lies inside the visible area.
module circle_octant_point
  import draw_pkg::*;
(
  input  logic [2:0]       octant,
  input  logic [X_W-1:0]   cx,
  input  logic [Y_W-1:0]   cy,
  input  logic signed [R_W:0] ox,
  input  logic signed [R_W:0] oy,
  output logic [X_W-1:0]   px,
  output logic [Y_W-1:0]   py,
  output logic             on_screen
);

  localparam int XS_W = X_W + 2;
  localparam int YS_W = Y_W + 2;
  localparam logic signed [XS_W-1:0] X_LIM = XS_W'(SCREEN_WIDTH);
  localparam logic signed [YS_W-1:0] Y_LIM = YS_W'(SCREEN_HEIGHT);

  logic signed [XS_W-1:0] cx_s, ox_x, oy_x, dx, px_s;
  logic signed [YS_W-1:0] cy_s, ox_y, oy_y, dy, py_s;

  assign cx_s = {2'b00, cx};
  assign cy_s = {2'b00, cy};
  assign ox_x = {{(XS_W-R_W-1){ox[R_W]}}, ox};
  assign oy_x = {{(XS_W-R_W-1){oy[R_W]}}, oy};
  assign ox_y = {{(YS_W-R_W-1){ox[R_W]}}, ox};
  assign oy_y = {{(YS_W-R_W-1){oy[R_W]}}, oy};

  // Octant bit 0 swaps the offsets, bit 1 mirrors x, bit 2 mirrors y.
  always_comb begin
    dx   = octant[0] ? oy_x : ox_x;
    dy   = octant[0] ? ox_y : oy_y;
    px_s = octant[1] ? (cx_s - dx) : (cx_s + dx);
    py_s = octant[2] ? (cy_s - dy) : (cy_s + dy);
  end

  assign on_screen = !px_s[XS_W-1] && (px_s < X_LIM) &&
                     !py_s[YS_W-1] && (py_s < Y_LIM);
  assign px = px_s[X_W-1:0];
  assign py = py_s[Y_W-1:0];

endmodule

// File: rtl/circle_pixel_engine.sv
// Midpoint circle rasteriser: one command in, a clipped stream of pixel
// writes out, finished with a single-cycle done pulse.
module circle_pixel_engine
  import draw_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] centre_x,
  input  logic [Y_W-1:0] centre_y,
  input  logic [R_W-1:0] radius,
  input  logic [2:0]     colour_in,
  input  logic           ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           busy,
  output logic           done
);

  localparam logic signed [R_W:0]   ONE_R  = (R_W+1)'(1);
  localparam logic signed [C_W-1:0] C_ZERO = '0;
  localparam logic signed [C_W-1:0] C_ONE  = C_W'(1);

  state_e                state_q, state_d;
  logic [2:0]            octant_q, octant_d;
  logic [X_W-1:0]        cx_q, cx_d;
  logic [Y_W-1:0]        cy_q, cy_d;
  logic [2:0]            col_q, col_d;
  logic signed [R_W:0]   ox_q, ox_d, oy_q, oy_d;
  logic signed [C_W-1:0] crit_q, crit_d;

  logic [X_W-1:0]        px;
  logic [Y_W-1:0]        py;
  logic                  on_screen;
  logic                  advance;
  logic                  crit_le0;
  logic signed [R_W:0]   oy_inc, ox_dec, ox_upd;
  logic signed [C_W-1:0] oy_e, ox_e, crit_upd;

  circle_octant_point u_point (
    .octant    (octant_q),
    .cx        (cx_q),
    .cy        (cy_q),
    .ox        (ox_q),
    .oy        (oy_q),
    .px        (px),
    .py        (py),
    .on_screen (on_screen)
  );

  // Midpoint step: both branches use the already-updated oy and ox.
  always_comb begin
    oy_inc   = oy_q + ONE_R;
    ox_dec   = ox_q - ONE_R;
    crit_le0 = (crit_q <= C_ZERO);
    ox_upd   = crit_le0 ? ox_q : ox_dec;
    oy_e     = {{(C_W-R_W-1){oy_inc[R_W]}}, oy_inc};
    ox_e     = {{(C_W-R_W-1){ox_upd[R_W]}}, ox_upd};
    crit_upd = crit_le0 ? (crit_q + (oy_e <<< 1) + C_ONE)
                        : (crit_q + ((oy_e - ox_e) <<< 1) + C_ONE);
  end

  // plot is the valid flag: a pixel transfers on any cycle with
  // plot && ready, and x/y/colour stay frozen while plot && !ready.
  always_comb begin
    state_d  = state_q;
    octant_d = octant_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    col_d    = col_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    crit_d   = crit_q;
    plot     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    x        = '0;
    y        = '0;
    colour   = '0;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cx_d     = centre_x;
          cy_d     = centre_y;
          col_d    = colour_in;
          ox_d     = {1'b0, radius};
          oy_d     = '0;
          crit_d   = C_ONE - $signed({3'b000, radius});
          octant_d = 3'd0;
          state_d  = PLOT;
        end
      end
      PLOT: begin
        busy = 1'b1;
        if (on_screen) begin
          plot    = 1'b1;
          x       = px;
          y       = py;
          colour  = col_q;
          advance = ready;
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          if (octant_q == 3'd7) begin
            state_d = UPDATE;
          end else begin
            octant_d = octant_q + 3'd1;
          end
        end
      end
      UPDATE: begin
        busy     = 1'b1;
        oy_d     = oy_inc;
        ox_d     = ox_upd;
        crit_d   = crit_upd;
        octant_d = 3'd0;
        state_d  = (oy_inc <= ox_upd) ? PLOT : DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      octant_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      col_q    <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      crit_q   <= '0;
    end else begin
      state_q  <= state_d;
      octant_q <= octant_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      col_q    <= col_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      crit_q   <= crit_d;
    end
  end

endmodule

// File: tb/tb_circle_pixel_engine.sv
// Bench for circle_pixel_engine: directed scenarios plus randomised
// commands and ready patterns, checked against an integer circle model.
module tb_circle_pixel_engine;
  import draw_pkg::*;

  logic       clk = 1'b0;
  logic       reset, start, ready;
  logic [7:0] centre_x;
  logic [6:0] centre_y;
  logic [6:0] radius;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  circle_pixel_engine dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .start     (start),
    .centre_x  (centre_x),
    .centre_y  (centre_y),
    .radius    (radius),
    .colour_in (colour_in),
    .ready     (ready),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [17:0] exp_q[$];
  int          exp_iters;
  logic [17:0] obs_q[$];
  int          obs_cyc[$];
  int          done_cyc, done_cnt, busy_cnt, hold_viol, range_viol, tail_plots;
  logic        busy_at1, busy_at_done;
  logic [20:0] post_rst;

  function automatic logic [17:0] pk(input int px, input int py, input logic [2:0] c);
    return {px[7:0], py[6:0], c};
  endfunction

  // Reference: integer midpoint circle, points listed in octant order.
  task automatic build_model(input int cx, input int cy, input int r, input logic [2:0] col);
    int ox, oy, crit, px, py;
    int dxs[8];
    int dys[8];
    exp_q.delete();
    exp_iters = 0;
    ox = r; oy = 0; crit = 1 - r;
    do begin
      dxs = '{ox, oy, -ox, -oy, ox, oy, -ox, -oy};
      dys = '{oy, ox, oy, ox, -oy, -ox, -oy, -ox};
      for (int i = 0; i < 8; i++) begin
        px = cx + dxs[i];
        py = cy + dys[i];
        if (px >= 0 && px < SCREEN_WIDTH && py >= 0 && py < SCREEN_HEIGHT)
          exp_q.push_back(pk(px, py, col));
      end
      exp_iters++;
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end while (oy <= ox);
  endtask

  // Driver/monitor: issues one command and records what comes out.
  // rmode 0: ready=1, 1: ready toggles 1,0,.., 2: random ready.
  task automatic run_cmd(input int cx, input int cy, input int r, input logic [2:0] col,
                         input int rmode, input int restart_cyc, input int abort_at);
    logic       held;
    logic [17:0] held_pix;
    obs_q.delete(); obs_cyc.delete();
    done_cyc = -1; done_cnt = 0; busy_cnt = 0; hold_viol = 0; range_viol = 0;
    tail_plots = 0; busy_at1 = 1'b0; busy_at_done = 1'b1; post_rst = '1;
    held = 1'b0; held_pix = '0;
    @(negedge clk);
    centre_x = cx[7:0]; centre_y = cy[6:0]; radius = r[6:0]; colour_in = col;
    start = 1'b1; ready = 1'b0;
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      start = (k == restart_cyc);
      if (start) begin
        centre_x = 8'($urandom); centre_y = 7'($urandom);
        radius = 7'($urandom); colour_in = 3'($urandom);
      end
      case (rmode)
        0: ready = 1'b1;
        1: ready = (k % 2 == 1);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (k == 1) busy_at1 = busy;
      if (busy) busy_cnt++;
      if (held && (!plot || {x, y, colour} != held_pix)) hold_viol++;
      held = plot && !ready;
      held_pix = {x, y, colour};
      if (plot && (int'(x) >= SCREEN_WIDTH || int'(y) >= SCREEN_HEIGHT)) range_viol++;
      if (plot && ready) begin
        obs_q.push_back({x, y, colour});
        obs_cyc.push_back(k);
      end
      if (abort_at > 0 && obs_q.size() == abort_at && plot && ready) begin
        reset = 1'b1;
        @(negedge clk); #1;
        post_rst = {plot, busy, done, x, y, colour};
        reset = 1'b0;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk); #1;
          if (done) done_cnt++;
          if (plot) tail_plots++;
        end
        return;
      end
      if (done) begin
        done_cnt++;
        done_cyc = k;
        busy_at_done = busy;
        if (restart_cyc > 0) start = 1'b1;
        break;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic cmp_stream(input string name);
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL %s pixel[%0d]: got %h expected %h", name, i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (done_cnt != 1) begin
      bad++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    end
    total++;
    if (hold_viol != 0 || range_viol != 0) begin
      bad++;
      $display("FAIL %s hold/range: got %0d/%0d expected 0/0", name, hold_viol, range_viol);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; ready = 1'b0;
    centre_x = '0; centre_y = '0; radius = '0; colour_in = '0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({plot, busy, done, x, y, colour} !== 21'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected 0", {plot, busy, done, x, y, colour});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({plot, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL idle_after_reset: got %b expected 000", {plot, busy, done});
    end
  endtask

  task automatic test_radius1;
    build_model(10, 10, 1, WHITE);
    run_cmd(10, 10, 1, WHITE, 0, 0, 0);
    cmp_stream("radius1");
    for (int i = 0; i < obs_cyc.size(); i++) begin
      total++;
      if (obs_cyc[i] != i + i / 8 + 1) begin
        bad++;
        $display("FAIL radius1 timing[%0d]: got cycle %0d expected %0d", i, obs_cyc[i], i + i / 8 + 1);
      end
    end
    total++;
    if (obs_q.size() < 9 || obs_q[0] !== pk(11, 10, WHITE) || obs_q[8] !== pk(11, 11, WHITE)) begin
      bad++;
      $display("FAIL radius1 key_points: got size %0d expected (11,10) then (11,11)", obs_q.size());
    end
    total++;
    if (done_cyc != 19 || busy_cnt != 18 || !busy_at1 || busy_at_done) begin
      bad++;
      $display("FAIL radius1 done/busy: got done@%0d busy=%0d expected done@19 busy=18", done_cyc, busy_cnt);
    end
  endtask

  task automatic test_ready_toggle;
    build_model(10, 10, 1, WHITE);
    run_cmd(10, 10, 1, WHITE, 1, 0, 0);
    cmp_stream("ready_toggle");
  endtask

  task automatic test_clip_origin;
    build_model(0, 0, 2, YELLOW);
    run_cmd(0, 0, 2, YELLOW, 0, 0, 0);
    cmp_stream("clip_origin");
    total++;
    if (done_cyc != 9 * exp_iters + 1) begin
      bad++;
      $display("FAIL clip_origin done_cycle: got %0d expected %0d", done_cyc, 9 * exp_iters + 1);
    end
    build_model(159, 119, 3, GREEN);
    run_cmd(159, 119, 3, GREEN, 2, 0, 0);
    cmp_stream("clip_far_corner");
  endtask

  task automatic test_radius0;
    run_cmd(80, 60, 0, RED, 0, 0, 0);
    total++;
    if (obs_q.size() != 8) begin
      bad++;
      $display("FAIL radius0 count: got %0d expected 8", obs_q.size());
    end
    foreach (obs_q[i]) begin
      total++;
      if (obs_q[i] !== pk(80, 60, 3'b100)) begin
        bad++;
        $display("FAIL radius0 pixel[%0d]: got %h expected %h", i, obs_q[i], pk(80, 60, 3'b100));
      end
    end
    total++;
    if (done_cyc != 10 || done_cnt != 1) begin
      bad++;
      $display("FAIL radius0 done: got cycle %0d count %0d expected cycle 10 count 1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    build_model(30, 40, 5, GREEN);
    run_cmd(30, 40, 5, GREEN, 0, 3, 0);
    cmp_stream("restart_ignored");
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); #1;
      if (plot || busy) tail_plots++;
    end
    total++;
    if (tail_plots != 0) begin
      bad++;
      $display("FAIL restart_idle_after_done: got %0d active cycles expected 0", tail_plots);
    end
  endtask

  task automatic test_reset_mid;
    run_cmd(80, 60, 20, BLUE, 0, 0, 5);
    total++;
    if (post_rst !== 21'd0) begin
      bad++;
      $display("FAIL midreset_outputs: got %h expected 0", post_rst);
    end
    total++;
    if (done_cnt != 0 || tail_plots != 0) begin
      bad++;
      $display("FAIL midreset_quiet: got done=%0d plots=%0d expected 0/0", done_cnt, tail_plots);
    end
    build_model(80, 60, 20, BLUE);
    run_cmd(80, 60, 20, BLUE, 2, 0, 0);
    cmp_stream("after_midreset");
  endtask

  task automatic test_random;
    int cx, cy, r;
    logic [2:0] col;
    for (int n = 0; n < 8; n++) begin
      cx = $urandom_range(0, 200);
      cy = $urandom_range(0, 127);
      r = $urandom_range(0, 30);
      col = 3'($urandom);
      build_model(cx, cy, r, col);
      run_cmd(cx, cy, r, col, 2, 0, 0);
      cmp_stream("random");
    end
  endtask

  initial begin
    test_reset();
    test_radius1();
    test_ready_toggle();
    test_clip_origin();
    test_radius0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
